// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MISS  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] WORD_ALIGN_MASK   = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues I-cache fetches, waits out misses,
// applies redirects and decode stalls, and drives the IF/ID register.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_ready,
  input  logic [31:0] icache_rdata,
  output logic [31:0] pc,
  output logic        pc_stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         advance;

  // Handshake: the cache sees icache_req/icache_addr; icache_ready marks rdata valid
  // in that cycle. The address is the PC register, so it cannot move until ready.
  assign icache_req  = ~rst;
  assign icache_addr = pc_q;
  assign pc          = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

  // The PC only advances when an instruction is actually accepted into IF/ID.
  assign advance  = ~rst & ~redirect_valid & icache_ready & ~hazard_stall &
                    ((state_q == ST_RUN) || (state_q == ST_MISS));
  assign pc_stall = ~advance;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    case (state_q)
      ST_RUN: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          if (icache_ready) begin
            pc_d = word_align(redirect_pc);
          end else begin
            pend_pc_d = word_align(redirect_pc);
            state_d   = ST_DRAIN;
          end
        end else if (icache_ready) begin
          if (!hazard_stall) begin
            valid_d    = 1'b1;
            instr_d    = icache_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
          end
        end else begin
          state_d = ST_MISS;
          if (!hazard_stall) valid_d = 1'b0;
        end
      end

      ST_MISS: begin
        if (redirect_valid) begin
          pend_pc_d = word_align(redirect_pc);
          valid_d   = 1'b0;
          state_d   = ST_DRAIN;
        end else if (icache_ready) begin
          // Under a hazard the refilled line is dropped and refetched as a hit.
          state_d = ST_RUN;
          if (!hazard_stall) begin
            valid_d    = 1'b1;
            instr_d    = icache_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
          end
        end else if (!hazard_stall) begin
          valid_d = 1'b0;
        end
      end

      ST_DRAIN: begin
        valid_d = 1'b0;
        if (redirect_valid) pend_pc_d = word_align(redirect_pc);
        if (icache_ready) begin
          pc_d    = pend_pc_d;
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      pend_pc_q  <= 32'h0;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: hits, misses, redirects, hazards, reset mid-miss, PC wrap.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        hazard_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_ready;
  logic [31:0] icache_rdata;
  logic [31:0] pc;
  logic        pc_stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int n_checks;
  int n_fail;

  fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .hazard_stall  (hazard_stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .icache_req    (icache_req),
    .icache_addr   (icache_addr),
    .icache_ready  (icache_ready),
    .icache_rdata  (icache_rdata),
    .pc            (pc),
    .pc_stall      (pc_stall),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed 1ns after the edge, outputs read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic [31:0] rdata, input logic redir,
                       input logic [31:0] rpc, input logic haz);
    icache_ready   = rdy;
    icache_rdata   = rdata;
    redirect_valid = redir;
    redirect_pc    = rpc;
    hazard_stall   = haz;
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] ipc);
    check({tag, ".valid"}, {31'b0, instr_valid}, {31'b0, v});
    if (v) begin
      check({tag, ".instr"}, instr, ins);
      check({tag, ".instr_pc"}, instr_pc, ipc);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    step();
    check("rst.req", {31'b0, icache_req}, 32'd0);
    check("rst.pc_stall", {31'b0, pc_stall}, 32'd1);
    step();
    check("rst.pc", pc, 32'h0);
    check("rst.valid", {31'b0, instr_valid}, 32'd0);
    check("rst.instr", instr, 32'h0000_0013);
    check("rst.instr_pc", instr_pc, 32'h0);

    // Four back-to-back hits
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA0 + i, 1'b0, 32'h0, 1'b0);
      #1;
      check("hit.req", {31'b0, icache_req}, 32'd1);
      check("hit.addr", icache_addr, 32'(4 * i));
      check("hit.pc_stall", {31'b0, pc_stall}, 32'd0);
      step();
      check_ifid("hit", 1'b1, 32'hA0 + i, 32'(4 * i));
      check("hit.pc", pc, 32'(4 * i + 4));
    end

    // Three-cycle miss at 0x10
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'hBAD, 1'b0, 32'h0, 1'b0);
      #1;
      check("miss.addr", icache_addr, 32'h10);
      check("miss.pc_stall", {31'b0, pc_stall}, 32'd1);
      step();
      check("miss.valid", {31'b0, instr_valid}, 32'd0);
    end
    drive(1'b1, 32'hB4, 1'b0, 32'h0, 1'b0);
    #1;
    check("miss.ready_stall", {31'b0, pc_stall}, 32'd0);
    step();
    check_ifid("miss.fill", 1'b1, 32'hB4, 32'h10);
    check("miss.pc", pc, 32'h14);

    // Hits up to 0x20, then redirect on a hit to unaligned 0x103
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hC0 + i, 1'b0, 32'h0, 1'b0);
      step();
    end
    check("pre_redir.pc", pc, 32'h20);
    drive(1'b1, 32'hBAD, 1'b1, 32'h103, 1'b0);
    #1;
    check("redir.pc_stall", {31'b0, pc_stall}, 32'd1);
    step();
    check("redir.pc", pc, 32'h100);
    check("redir.valid", {31'b0, instr_valid}, 32'd0);
    drive(1'b1, 32'hC8, 1'b0, 32'h0, 1'b0);
    step();
    check_ifid("redir.tgt", 1'b1, 32'hC8, 32'h100);
    check("redir.pc2", pc, 32'h104);

    // Miss, redirect to 0x200, then 0x300 before the refill completes
    drive(1'b0, 32'hBAD, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 32'hBAD, 1'b1, 32'h200, 1'b0);
    step();
    check("drain.valid1", {31'b0, instr_valid}, 32'd0);
    drive(1'b0, 32'hBAD, 1'b0, 32'h0, 1'b0);
    step();
    check("drain.addr", icache_addr, 32'h104);
    drive(1'b0, 32'hBAD, 1'b1, 32'h300, 1'b0);
    step();
    check("drain.valid2", {31'b0, instr_valid}, 32'd0);
    drive(1'b1, 32'hDEAD, 1'b0, 32'h0, 1'b0);
    #1;
    check("drain.pc_stall", {31'b0, pc_stall}, 32'd1);
    step();
    check("drain.pc", pc, 32'h300);
    check("drain.discard", {31'b0, instr_valid}, 32'd0);
    drive(1'b1, 32'hD0, 1'b0, 32'h0, 1'b0);
    step();
    check_ifid("drain.tgt", 1'b1, 32'hD0, 32'h300);

    // Hazard for one cycle, then hazard plus redirect
    drive(1'b1, 32'hE0, 1'b0, 32'h0, 1'b1);
    #1;
    check("haz.pc_stall", {31'b0, pc_stall}, 32'd1);
    step();
    check_ifid("haz.hold", 1'b1, 32'hD0, 32'h300);
    check("haz.pc", pc, 32'h304);
    drive(1'b1, 32'hE4, 1'b1, 32'h400, 1'b1);
    step();
    check("haz_redir.valid", {31'b0, instr_valid}, 32'd0);
    check("haz_redir.pc", pc, 32'h400);

    // Reset in the middle of a miss
    drive(1'b0, 32'hBAD, 1'b0, 32'h0, 1'b0);
    step();
    rst = 1'b1;
    #1;
    check("rst_miss.req", {31'b0, icache_req}, 32'd0);
    step();
    rst = 1'b0;
    check("rst_miss.pc", pc, 32'h0);
    check("rst_miss.instr", instr, 32'h0000_0013);
    check("rst_miss.valid", {31'b0, instr_valid}, 32'd0);

    // Redirect to the top word, then let the PC wrap
    drive(1'b1, 32'hBAD, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step();
    check("wrap.redir_pc", pc, 32'hFFFF_FFFC);
    drive(1'b1, 32'hF0, 1'b0, 32'h0, 1'b0);
    step();
    check_ifid("wrap", 1'b1, 32'hF0, 32'hFFFF_FFFC);
    check("wrap.pc", pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer between the PC datapath and the instruction cache. It owns the PC register and issues fetches to the I-cache. It waits out cache misses, applies branch/jump redirects, and honours decode hazard stalls. It drives the IF/ID pipeline register and produces the PC-hold (stall) signal used by the PC+4 adder.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID on reset (addi x0,x0,0)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
hazard_stall  in  1  decode hazard; hold PC and IF/ID
redirect_valid  in  1  taken branch/jump this cycle
redirect_pc  in  32  redirect target
icache_req  out  1  fetch request
icache_addr  out  32  fetch address (= current PC)
icache_ready  in  1  same-cycle hit / refill-complete; rdata valid
icache_rdata  in  32  fetched instruction
pc  out  32  current PC register
pc_stall  out  1  1 = PC not advancing this cycle (to PC+4 stall input)
instr_valid  out  1  IF/ID valid
instr  out  32  IF/ID instruction
instr_pc  out  32  IF/ID instruction address

Behaviour:
- Reset (rst=1 at a clock edge): pc<=RESET_PC, state<=RUN, pend_pc<=0, instr_valid<=0, instr<=NOP_INSTR, instr_pc<=0. icache_req=0 while rst=1; otherwise icache_req=1.
- Reset mid-miss abandons the refill. The cache shares rst.
- icache_addr=pc, combinational. The address is stable while icache_ready=0; the cache requires this.
- redirect_pc[1:0] is forced to 2'b00 on load.
- pc+4 wraps modulo 2^32.
- States: RUN, MISS, DRAIN.
- RUN, redirect_valid & icache_ready: pc<=redirect_pc; instr_valid<=0. Redirect beats hazard_stall.
- RUN, redirect_valid & !icache_ready: pend_pc<=redirect_pc; instr_valid<=0; ->DRAIN.
- RUN, no redirect, icache_ready & !hazard_stall: IF/ID<={1, rdata, pc}; pc<=pc+4. Throughput is one instruction per cycle on hits.
- RUN, no redirect, icache_ready & hazard_stall: pc and IF/ID hold.
- RUN, no redirect, !icache_ready: ->MISS. If hazard_stall, IF/ID holds; else instr_valid<=0.
- MISS, redirect_valid: pend_pc<=redirect_pc; instr_valid<=0; ->DRAIN.
- MISS, icache_ready & !hazard_stall: capture into IF/ID; pc<=pc+4; ->RUN.
- MISS, icache_ready & hazard_stall: ->RUN. pc holds; the line is refetched as a hit.
- MISS, !icache_ready: IF/ID holds if hazard_stall, else instr_valid<=0.
- DRAIN: instr_valid<=0 every cycle. A further redirect_valid overwrites pend_pc (latest wins). On icache_ready: rdata is discarded; pc<=pend_pc; ->RUN.
- pc_stall=1 whenever pc does not take pc+4 at the next edge. This includes redirect loads, misses, hazard and rst.
- Hazard_stall and redirect_valid in the same cycle: the redirect wins and IF/ID is flushed.
- Latency:
  - Hit: PC issued in cycle N, IF/ID valid at edge N+1.
  - Miss: IF/ID valid one edge after icache_ready.

Decomposition:
- Shared package fetch_pkg:
  - State enum (RUN, MISS, DRAIN).
  - NOP_INSTR and RESET_PC defaults.
  - Word-align mask.
- No sub-module required. The IF/ID register may be split out as ifid_reg (valid/instr/pc with hold and flush inputs) if the decode team reuses it.

Test Plan:
- Reset then icache_ready=1 for 4 cycles, rdata=0xA0..A3 -> instr_pc 0,4,8,C with matching instr; instr_valid=1 from the 2nd edge; pc_stall=0.
- Miss: icache_ready low for 3 cycles at pc=0x10 -> icache_addr stays 0x10; instr_valid=0; pc_stall=1; on ready, instr_pc=0x10 and pc=0x14.
- Redirect on a hit at pc=0x20, redirect_pc=0x103 -> pc=0x100 next cycle; instr_valid=0 for one cycle; then instr_pc=0x100.
- Redirect during a miss to 0x200, then a second redirect to 0x300 before ready -> data discarded; pc=0x300 after ready; no valid instr from 0x200 or the missed line.
- hazard_stall for 2 cycles with redirect on the 2nd -> IF/ID holds in cycle 1; flushed (instr_valid=0) and pc=target after cycle 2.
- rst asserted mid-miss, then PC near wrap (redirect 0xFFFF_FFFC, hit) -> after reset pc=RESET_PC and instr=NOP_INSTR; after the redirect, the next pc=0x0000_0000.
